mp_reg_file_sb: RTL and testbench

Parametrised multi-port register file with an integrated busy scoreboard for the superscalar MIPS datapath. It replaces the fixed three-way register file with one sized by write-port count, register count and data width. Each write port has two read ports. The block adds same-cycle write-to-read bypass, deterministic write-conflict resolution and per-register busy tracking. It sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/mp_reg_file_sb_pkg.sv | 15 +
 rtl/mp_reg_file_sb_wsel.sv | 31 +++
 rtl/mp_reg_file_sb.sv | 115 +++++++++++
 tb/tb_mp_reg_file_sb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_reg_file_sb_pkg.sv
// Shared defaults for the multi-port register file.
// Packing helpers keep decode, issue and writeback on one bus layout.
package mp_reg_file_sb_pkg;

  localparam int NW_DEF       = 3;
  localparam int AW_DEF       = 5;
  localparam int DW_DEF       = 32;
  localparam int ZERO_REG_DEF = 1;

  // Bit offset of port k in a bus packed with fields of width w.
  function automatic int slot_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/mp_reg_file_sb_wsel.sv
// Priority selector over the write ports.
// The highest-index matching port wins, which mirrors program order.
module mp_reg_file_sb_wsel
  import mp_reg_file_sb_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic [AW-1:0]    i_addr,
  input  logic [NW-1:0]    i_we,
  input  logic [NW*AW-1:0] i_wr_addr,
  input  logic [NW*DW-1:0] i_wr_data,
  output logic             o_hit,
  output logic [DW-1:0]    o_data
);

  // Later ports overwrite earlier matches.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int p = 0; p < NW; p++) begin
      if (i_we[p] &&
          i_wr_addr[slot_lo(p, AW) +: AW] == i_addr) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[slot_lo(p, DW) +: DW];
      end
    end
  end

endmodule

// File: rtl/mp_reg_file_sb.sv
// Multi-port register file with write bypass and busy scoreboard.
// Reads are combinational; writes and reserves land at the clock edge.
module mp_reg_file_sb
  import mp_reg_file_sb_pkg::*;
#(
  parameter int NW       = NW_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NW*AW-1:0]    rd_addr,
  output logic [2*NW*DW-1:0]    rd_data,
  output logic [2*NW-1:0]       rd_busy,
  input  logic [NW-1:0]         we,
  input  logic [NW*AW-1:0]      wr_addr,
  input  logic [NW*DW-1:0]      wr_data,
  input  logic [NW-1:0]         rsv_en,
  input  logic [NW*AW-1:0]      rsv_addr,
  output logic [(1<<AW)-1:0]    busy_vec
);

  localparam int NR   = 2 * NW;
  localparam int NREG = 1 << AW;

  logic [DW-1:0]   r_mem [NREG];
  logic [NREG-1:0] r_busy;

  logic [NREG-1:0] w_whit;
  logic [NREG-1:0] w_wen;
  logic [NREG-1:0] w_rsv;
  logic [DW-1:0]   w_wdat [NREG];

  // Per-register write decision.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    mp_reg_file_sb_wsel #(
      .NW (NW),
      .AW (AW),
      .DW (DW)
    ) u_wsel (
      .i_addr    (AW'(r)),
      .i_we      (we),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_hit     (w_whit[r]),
      .o_data    (w_wdat[r])
    );
    if (ZERO_REG != 0 && r == 0) begin : g_zero
      assign w_wen[r] = 1'b0;
    end else begin : g_norm
      assign w_wen[r] = w_whit[r];
    end
  end

  // Reserve requests decoded per register; repeats collapse.
  always_comb begin
    w_rsv = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int p = 0; p < NW; p++) begin
        if (rsv_en[p] &&
            rsv_addr[slot_lo(p, AW) +: AW] == AW'(r))
          w_rsv[r] = 1'b1;
      end
    end
    if (ZERO_REG != 0) w_rsv[0] = 1'b0;
  end

  // Storage and scoreboard; a new reserve beats a completing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_wen[r]) r_mem[r] <= w_wdat[r];
        r_busy[r] <= w_rsv[r] | (r_busy[r] & ~w_wen[r]);
      end
    end
  end

  // Read ports with same-cycle bypass; reset forces zeros.
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_z;
    logic          w_bhit;
    logic [DW-1:0] w_bdat;

    assign w_ra = rd_addr[k*AW +: AW];
    assign w_z  = (ZERO_REG != 0) && (w_ra == '0);

    mp_reg_file_sb_wsel #(
      .NW (NW),
      .AW (AW),
      .DW (DW)
    ) u_byp (
      .i_addr    (w_ra),
      .i_we      (we),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_hit     (w_bhit),
      .o_data    (w_bdat)
    );

    assign rd_data[k*DW +: DW] =
      (!rst_n || w_z) ? '0 :
      w_bhit          ? w_bdat :
                        r_mem[w_ra];
    assign rd_busy[k] =
      rst_n & ~w_z & ~w_bhit & r_busy[w_ra];
  end

  assign busy_vec = rst_n ? r_busy : '0;

endmodule

// File: tb/tb_mp_reg_file_sb.sv
// Bench for mp_reg_file_sb: directed scenarios plus random traffic
// checked every cycle against an array-based reference model.
module tb_mp_reg_file_sb;

  localparam int NW   = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 2 * NW;
  localparam int NREG = 1 << AW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR*AW-1:0]    rd_addr;
  logic [NR*DW-1:0]    rd_data;
  logic [NR-1:0]       rd_busy;
  logic [NW-1:0]       we;
  logic [NW*AW-1:0]    wr_addr;
  logic [NW*DW-1:0]    wr_data;
  logic [NW-1:0]       rsv_en;
  logic [NW*AW-1:0]    rsv_addr;
  logic [NREG-1:0]     busy_vec;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;

  always #5 clk = ~clk;

  mp_reg_file_sb #(
    .NW(NW), .AW(AW), .DW(DW), .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  // Reference model state update: program order within the group.
  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0]   t_mem [NREG];
    logic [NREG-1:0] t_busy;
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) m_mem[r] <= '0;
      m_busy <= '0;
    end else begin
      t_mem  = m_mem;
      t_busy = m_busy;
      for (int p = 0; p < NW; p++) begin
        int a;
        a = int'(wr_addr[p*AW +: AW]);
        if (we[p] && a != 0) begin
          t_mem[a]  = wr_data[p*DW +: DW];
          t_busy[a] = 1'b0;
        end
      end
      for (int p = 0; p < NW; p++) begin
        int a;
        a = int'(rsv_addr[p*AW +: AW]);
        if (rsv_en[p] && a != 0) t_busy[a] = 1'b1;
      end
      m_mem  <= t_mem;
      m_busy <= t_busy;
    end
  end

  // Cycle checker: expected outputs from model state and live inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        int a;
        logic [DW-1:0] ed;
        logic eb;
        logic hit;
        a   = int'(rd_addr[k*AW +: AW]);
        hit = 1'b0;
        ed  = m_mem[a];
        for (int p = 0; p < NW; p++) begin
          if (we[p] && int'(wr_addr[p*AW +: AW]) == a) begin
            hit = 1'b1;
            ed  = wr_data[p*DW +: DW];
          end
        end
        if (!rst_n || a == 0) ed = '0;
        eb = rst_n && a != 0 && !hit && m_busy[a];
        n_tests++;
        if (rd_data[k*DW +: DW] !== ed) begin
          n_fail++;
          $display("FAIL model_rd_data port%0d t=%0t got %h exp %h",
                   k, $time, rd_data[k*DW +: DW], ed);
        end
        n_tests++;
        if (rd_busy[k] !== eb) begin
          n_fail++;
          $display("FAIL model_rd_busy port%0d t=%0t got %b exp %b",
                   k, $time, rd_busy[k], eb);
        end
      end
      n_tests++;
      if (busy_vec !== (rst_n ? m_busy : '0)) begin
        n_fail++;
        $display("FAIL model_busy_vec t=%0t got %h exp %h",
                 $time, busy_vec, rst_n ? m_busy : '0);
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    we = '0; wr_addr = '0; wr_data = '0;
    rsv_en = '0; rsv_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rsv(input int p, input int a);
    rsv_en[p] = 1'b1;
    rsv_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic rd_all(input int a);
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    idle();
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    lit("reset_busy_vec", 64'(busy_vec), 64'd0);
    lit("reset_rd_data", 64'(rd_data[DW-1:0]), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Fill r1..r31 through rotating ports.
    for (int r = 1; r < NREG; r++) begin
      idle();
      wr(r % NW, r, DW'(r));
      step();
    end
    idle();
    for (int r = 0; r < NREG; r++) begin
      rd_all(r);
      @(negedge clk);
      if (r == 0 || r == 5 || r == 31)
        lit($sformatf("fill_r%0d", r),
            64'(rd_data[DW-1:0]), 64'(r));
      step();
    end

    // Three-way conflict on r5.
    wr(0, 5, 32'h11); wr(1, 5, 32'h22); wr(2, 5, 32'h33);
    rd_all(5);
    @(negedge clk);
    lit("conflict_bypass", 64'(rd_data[DW-1:0]), 64'h33);
    step();
    idle();
    @(negedge clk);
    lit("conflict_stored", 64'(rd_data[DW-1:0]), 64'h33);
    step();

    // Bypass and zero register.
    wr(0, 9, 32'hABCD); wr(1, 0, 32'hFFFF);
    for (int k = 0; k < NR; k++)
      rd_addr[k*AW +: AW] = AW'((k % 2 == 0) ? 9 : 0);
    @(negedge clk);
    lit("bypass_r9", 64'(rd_data[2*DW +: DW]), 64'hABCD);
    lit("bypass_r0", 64'(rd_data[DW +: DW]), 64'h0);
    step();
    idle();
    @(negedge clk);
    lit("stored_r0", 64'(rd_data[3*DW +: DW]), 64'h0);
    lit("stored_r9", 64'(rd_data[0 +: DW]), 64'hABCD);
    step();

    // Scoreboard sequence on r7.
    rd_all(7);
    rsv(1, 7);
    @(negedge clk);
    lit("rsv_not_yet", 64'(rd_busy[0]), 64'd0);
    step();
    idle();
    @(negedge clk);
    lit("rsv_busy_vec", 64'(busy_vec[7]), 64'd1);
    lit("rsv_rd_busy", 64'(rd_busy[0]), 64'd1);
    step();
    wr(2, 7, 32'h77);
    @(negedge clk);
    lit("clr_rd_busy", 64'(rd_busy[0]), 64'd0);
    step();
    idle();
    @(negedge clk);
    lit("clr_busy_vec", 64'(busy_vec[7]), 64'd0);
    step();
    rsv(0, 7); wr(2, 7, 32'h78);
    step();
    idle();
    @(negedge clk);
    lit("rsv_beats_clr", 64'(busy_vec[7]), 64'd1);
    step();

    // Mid-operation reset with r3 = 56 busy.
    wr(0, 3, 32'd56); rsv(1, 3);
    step();
    idle();
    rd_all(3);
    @(negedge clk);
    lit("pre_reset_r3", 64'(rd_data[DW-1:0]), 64'd56);
    step();
    rst_n = 1'b0;
    wr(0, 3, 32'd99);
    #1;
    lit("in_reset_rd_data", 64'(rd_data[DW-1:0]), 64'd0);
    lit("in_reset_busy_vec", 64'(busy_vec), 64'd0);
    step();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    lit("post_reset_r3", 64'(rd_data[DW-1:0]), 64'd0);
    step();

    // Random traffic, clustered addresses to force collisions.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NW; p++) begin
        we[p] = ($urandom_range(0, 99) < 60);
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[p*DW +: DW] = $urandom;
        rsv_en[p] = ($urandom_range(0, 99) < 40);
        rsv_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      end
      for (int k = 0; k < NR; k++)
        rd_addr[k*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ?
                              $urandom_range(0, NREG - 1) :
                              $urandom_range(0, 7));
      step();
    end

    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
